serial_alu_seq: RTL and testbench

//   Bit-serial ALU sequencer. Accepts two WIDTH-bit operands and an opcode, then drives
//   one 1-bit ALU slice LSB-first for WIDTH cycles, carrying between bits in a flop.

---
 rtl/serial_alu_seq_pkg.sv | 21 ++
 rtl/serial_alu_seq_slice.sv | 27 ++
 rtl/serial_alu_seq.sv | 118 +++++++++++
 tb/tb_serial_alu_seq.sv | 210 +++++++++++++++++++++
 4 files changed

// File: rtl/serial_alu_seq_pkg.sv
// Shared definitions for the bit-serial ALU sequencer and its 1-bit slice:
// opcode encodings, FSM state encoding and a small opcode helper.
package serial_alu_seq_pkg;

   localparam logic [1:0] OP_ADD = 2'b00;
   localparam logic [1:0] OP_SUB = 2'b01;
   localparam logic [1:0] OP_AND = 2'b10;
   localparam logic [1:0] OP_XOR = 2'b11;

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_SHIFT = 2'd1,
      S_DONE  = 2'd2
   } state_t;

   // ADD and SUB propagate a carry between bits; the logic ops do not.
   function automatic logic is_arith(input logic [1:0] op);
      return ~op[1];
   endfunction

endpackage

// File: rtl/serial_alu_seq_slice.sv
// Combinational 1-bit ALU slice. For SUB the caller supplies the inverted
// b bit and a carry-in of 1, so the slice itself only ever adds.
module alu_slice_1b
   import serial_alu_seq_pkg::*;
(
   input  logic       a,
   input  logic       b,
   input  logic       cin,
   input  logic [1:0] op,
   output logic       r,
   output logic       cout
);

   always_comb begin
      r    = 1'b0;
      cout = 1'b0;
      case (op)
         OP_ADD, OP_SUB: begin
            r    = a ^ b ^ cin;
            cout = (a & b) | (cin & (a ^ b));
         end
         OP_AND:  r = a & b;
         default: r = a ^ b;
      endcase
   end

endmodule

// File: rtl/serial_alu_seq.sv
// Bit-serial ALU sequencer: streams two WIDTH-bit operands LSB-first through a
// shared 1-bit slice and presents the assembled result with a one-cycle done pulse.
module serial_alu_seq
   import serial_alu_seq_pkg::*;
#(
   parameter int WIDTH = 8
)(
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [WIDTH-1:0] A,
   input  logic [WIDTH-1:0] B,
   input  logic [1:0]       OP,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] R,
   output logic             Cout,
   output logic             Z
);

   localparam int CNT_W = $clog2(WIDTH);

   state_t           r_state;
   state_t           w_state_next;
   logic [CNT_W-1:0] r_cnt;
   logic [WIDTH-1:0] r_a_sr;
   logic [WIDTH-1:0] r_b_sr;
   logic [WIDTH-1:0] r_res;
   logic [1:0]       r_op;
   logic             r_carry;
   logic             r_done;
   logic [WIDTH-1:0] r_r;
   logic             r_cout;
   logic             r_z;

   logic w_last;
   logic w_b;
   logic w_r;
   logic w_cout;

   assign w_last = (r_cnt == CNT_W'(WIDTH - 1));
   assign w_b    = r_b_sr[0] ^ (r_op == OP_SUB);

   alu_slice_1b u_slice (
      .a    (r_a_sr[0]),
      .b    (w_b),
      .cin  (r_carry),
      .op   (r_op),
      .r    (w_r),
      .cout (w_cout)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) r_state <= S_IDLE;
      else     r_state <= w_state_next;
   end

   always_comb begin
      w_state_next = r_state;
      case (r_state)
         S_IDLE:  if (start) w_state_next = S_SHIFT;
         S_SHIFT: if (w_last) w_state_next = S_DONE;
         S_DONE:  w_state_next = S_IDLE;
         default: w_state_next = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_cnt   <= '0;
         r_a_sr  <= '0;
         r_b_sr  <= '0;
         r_res   <= '0;
         r_op    <= OP_ADD;
         r_carry <= 1'b0;
         r_done  <= 1'b0;
         r_r     <= '0;
         r_cout  <= 1'b0;
         r_z     <= 1'b0;
      end else begin
         r_done <= 1'b0;
         case (r_state)
            S_IDLE: begin
               if (start) begin
                  r_a_sr  <= A;
                  r_b_sr  <= B;
                  r_op    <= OP;
                  r_carry <= (OP == OP_SUB);
                  r_res   <= '0;
                  r_cnt   <= '0;
               end
            end
            S_SHIFT: begin
               // Result enters at the MSB so bit 0 lands at the LSB after WIDTH shifts.
               r_res   <= {w_r, r_res[WIDTH-1:1]};
               r_a_sr  <= r_a_sr >> 1;
               r_b_sr  <= r_b_sr >> 1;
               r_carry <= is_arith(r_op) ? w_cout : 1'b0;
               if (!w_last) r_cnt <= r_cnt + 1'b1;
            end
            S_DONE: begin
               r_r    <= r_res;
               r_cout <= r_carry;
               r_z    <= (r_res == '0);
               r_done <= 1'b1;
            end
            default: ;
         endcase
      end
   end

   assign busy = (r_state != S_IDLE);
   assign done = r_done;
   assign R    = r_r;
   assign Cout = r_cout;
   assign Z    = r_z;

endmodule

// File: tb/tb_serial_alu_seq.sv
// Self-checking bench for serial_alu_seq (WIDTH=8): directed scenarios plus
// random operations compared against an arithmetic reference model.
module tb_serial_alu_seq;

   localparam int WIDTH = 8;

   logic             clk;
   logic             rst;
   logic             start;
   logic [WIDTH-1:0] A;
   logic [WIDTH-1:0] B;
   logic [1:0]       OP;
   logic             busy;
   logic             done;
   logic [WIDTH-1:0] R;
   logic             Cout;
   logic             Z;

   int n_checks = 0;
   int n_errors = 0;

   serial_alu_seq #(.WIDTH(WIDTH)) dut (
      .clk   (clk),
      .rst   (rst),
      .start (start),
      .A     (A),
      .B     (B),
      .OP    (OP),
      .busy  (busy),
      .done  (done),
      .R     (R),
      .Cout  (Cout),
      .Z     (Z)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Reference: {carry, result} from plain integer arithmetic.
   function automatic logic [WIDTH:0] ref_alu(input logic [WIDTH-1:0] a,
                                              input logic [WIDTH-1:0] b,
                                              input logic [1:0] op);
      int unsigned ia, ib, full;
      ia = a;
      ib = b;
      case (op)
         2'b00:   full = ia + ib;
         2'b01:   full = (ia >= ib) ? ((ia - ib) | (1 << WIDTH)) : ((ia + (1 << WIDTH) - ib) & ((1 << WIDTH) - 1));
         2'b10:   full = ia & ib;
         default: full = ia ^ ib;
      endcase
      return full[WIDTH:0];
   endfunction

   // Entered and left just after a rising edge.
   task automatic run_op(input string tag, input logic [WIDTH-1:0] a,
                         input logic [WIDTH-1:0] b, input logic [1:0] op);
      logic [WIDTH:0] exp;
      int cyc, bcnt;
      exp   = ref_alu(a, b, op);
      A     = a;
      B     = b;
      OP    = op;
      start = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      A     = WIDTH'($urandom);
      B     = WIDTH'($urandom);
      OP    = 2'($urandom);
      bcnt  = 0;
      for (cyc = 0; cyc < 40; cyc++) begin
         @(negedge clk);
         if (done) break;
         if (busy) bcnt++;
         @(posedge clk);
         #1;
      end
      check({tag, "_latency"}, cyc, WIDTH + 1);
      check({tag, "_busy"}, bcnt, WIDTH + 1);
      check({tag, "_R"}, R, exp[WIDTH-1:0]);
      check({tag, "_Cout"}, Cout, exp[WIDTH]);
      check({tag, "_Z"}, Z, (exp[WIDTH-1:0] == '0));
      $display("op %s A=%02h B=%02h OP=%0d -> R=%02h Cout=%0b Z=%0b", tag, a, b, op, R, Cout, Z);
      @(posedge clk);
      #1;
      check({tag, "_pulse"}, done, 1'b0);
   endtask

   initial begin
      int dn, last, k;
      logic [WIDTH-1:0] a3 [3];
      logic [WIDTH-1:0] b3 [3];
      logic [1:0]       o3 [3];
      logic [WIDTH:0]   e3 [3];

      rst = 1'b1; start = 1'b0; A = '0; B = '0; OP = 2'b00;
      #1;
      check("rst_state", {busy, done, R, Cout, Z}, '0);
      @(posedge clk);
      @(posedge clk);
      #1;
      rst = 1'b0;

      run_op("add7f", 8'h7F, 8'h01, 2'b00);
      run_op("addff", 8'hFF, 8'h01, 2'b00);
      run_op("sub57", 8'h05, 8'h07, 2'b01);
      run_op("sub75", 8'h07, 8'h05, 2'b01);
      run_op("and", 8'hF0, 8'h3C, 2'b10);
      run_op("xor", 8'hAA, 8'hAA, 2'b11);

      // start while busy must be ignored
      A = 8'h12; B = 8'h34; OP = 2'b00; start = 1'b1;
      @(posedge clk);
      #1;
      dn = 0;
      for (int c = 0; c < 20; c++) begin
         if (c == 3) begin
            start = 1'b1; A = 8'h55; B = 8'h66;
         end else begin
            start = 1'b0;
         end
         @(negedge clk);
         if (done) begin
            dn++;
            check("ign_R", R, 8'h46);
         end
         @(posedge clk);
         #1;
      end
      start = 1'b0;
      check("ign_dones", dn, 1);
      $display("op ignore-start dones=%0d R=%02h", dn, R);

      // asynchronous reset mid-SHIFT
      run_op("pre_rst", 8'h07, 8'h05, 2'b01);
      A = 8'h10; B = 8'h20; OP = 2'b00; start = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      repeat (4) @(posedge clk);
      #3;
      rst = 1'b1;
      #1;
      check("arst_busy", busy, 1'b0);
      check("arst_done", done, 1'b0);
      check("arst_R", R, '0);
      check("arst_Cout", Cout, 1'b0);
      check("arst_Z", Z, 1'b0);
      @(posedge clk);
      #1;
      rst = 1'b0;
      dn = 0;
      for (int c = 0; c < 12; c++) begin
         @(negedge clk);
         if (done) dn++;
      end
      @(posedge clk);
      #1;
      check("arst_nodone", dn, 0);
      $display("op async-reset abort dones=%0d", dn);
      run_op("post_rst", 8'h10, 8'h20, 2'b00);

      // start held high for three back-to-back operations
      a3[0] = 8'h11; b3[0] = 8'h22; o3[0] = 2'b00;
      a3[1] = 8'h30; b3[1] = 8'h31; o3[1] = 2'b01;
      a3[2] = 8'hC3; b3[2] = 8'h5A; o3[2] = 2'b11;
      for (int i = 0; i < 3; i++) e3[i] = ref_alu(a3[i], b3[i], o3[i]);
      A = a3[0]; B = b3[0]; OP = o3[0]; start = 1'b1;
      k = 0; last = 0;
      for (int c = 0; c < 60; c++) begin
         @(negedge clk);
         if (done) begin
            check("b2b_R", R, e3[k][WIDTH-1:0]);
            check("b2b_Cout", Cout, e3[k][WIDTH]);
            if (k > 0) check("b2b_spacing", c - last, WIDTH + 2);
            $display("op b2b[%0d] R=%02h Cout=%0b at cycle %0d", k, R, Cout, c);
            last = c;
            k++;
            if (k == 3) begin
               start = 1'b0;
               break;
            end
            A = a3[k]; B = b3[k]; OP = o3[k];
         end else if (k > 0) begin
            check("b2b_hold", R, e3[k-1][WIDTH-1:0]);
         end
      end
      start = 1'b0;
      check("b2b_count", k, 3);
      @(posedge clk);
      #1;

      for (int i = 0; i < 30; i++) begin
         run_op($sformatf("rnd%0d", i), WIDTH'($urandom), WIDTH'($urandom), 2'($urandom_range(0, 3)));
      end

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
